// File: rtl/matrix_add_sub_3x3.sv
`default_nettype none
// ============================================================================
// Module      : matrix_add_sub_3x3
// Description : Element-wise signed matrix adder/subtractor for M x P
//               operands. A and B live in internal register files loaded one
//               word per cycle through independent write ports. On start the
//               unit streams C = A + B (op=0) or C = A - B (op=1) row-major,
//               one element per cycle, then pulses done for one cycle.
// Ports       :
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   begin a run (sampled in IDLE only)
//   op           in   0 = add, 1 = subtract (latched on accepted start)
//   a_in/a_addr/a_wen   A write port (row-major address row*P+col)
//   b_in/b_addr/b_wen   B write port
//   c_out        out  registered result element
//   c_valid      out  c_out / i_count_out valid this cycle
//   done         out  one-cycle completion pulse
//   i_count_out  out  linear index of the element on c_out
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_add_sub_3x3 #(
    parameter  int M          = 3,
    parameter  int P          = 3,
    parameter  int DATA_WIDTH = 32,
    localparam int AW         = (M * P > 1) ? $clog2(M * P) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         op,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic        [AW-1:0]         a_addr,
    input  logic                         a_wen,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    input  logic        [AW-1:0]         b_addr,
    input  logic                         b_wen,
    output logic signed [DATA_WIDTH-1:0] c_out,
    output logic                         c_valid,
    output logic                         done,
    output logic        [AW-1:0]         i_count_out
);

    localparam int            c_N     = M * P;
    localparam logic [AW:0]   c_N_EXT = (AW + 1)'(c_N);
    localparam logic [AW-1:0] c_LAST  = AW'(c_N - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // ------------------------------------------------------------------
    // Operand storage
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] mem_a_q [c_N];
    logic signed [DATA_WIDTH-1:0] mem_b_q [c_N];

    // Addresses past the last element are dropped rather than aliased.
    logic w_a_wr;
    logic w_b_wr;
    assign w_a_wr = a_wen && ({1'b0, a_addr} < c_N_EXT);
    assign w_b_wr = b_wen && ({1'b0, b_addr} < c_N_EXT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_N; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else begin
            if (w_a_wr) begin
                mem_a_q[a_addr] <= a_in;
            end
            if (w_b_wr) begin
                mem_b_q[b_addr] <= b_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]                   state_q, state_d;
    logic [AW-1:0]                idx_q, idx_d;
    logic                         op_q, op_d;
    logic signed [DATA_WIDTH-1:0] c_out_q, c_out_d;
    logic                         c_valid_q, c_valid_d;
    logic                         done_q, done_d;
    logic [AW-1:0]                i_count_q, i_count_d;

    // State register (plus the registered datapath outputs).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_ST_IDLE;
            idx_q     <= '0;
            op_q      <= 1'b0;
            c_out_q   <= '0;
            c_valid_q <= 1'b0;
            done_q    <= 1'b0;
            i_count_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            c_out_q   <= c_out_d;
            c_valid_q <= c_valid_d;
            done_q    <= done_d;
            i_count_q <= i_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (start) state_d = c_ST_RUN;
            c_ST_RUN:  if (idx_q == c_LAST) state_d = c_ST_DONE;
            c_ST_DONE: state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    // Results use the register-file contents before the edge that
    // captures them; a same-cycle write lands only afterwards.
    logic signed [DATA_WIDTH-1:0] w_sum;
    logic signed [DATA_WIDTH-1:0] w_diff;
    assign w_sum  = mem_a_q[idx_q] + mem_b_q[idx_q];
    assign w_diff = mem_a_q[idx_q] - mem_b_q[idx_q];

    // Output / datapath logic. c_out and i_count_out hold when idle.
    always_comb begin
        idx_d     = idx_q;
        op_d      = op_q;
        c_out_d   = c_out_q;
        c_valid_d = 1'b0;
        done_d    = 1'b0;
        i_count_d = i_count_q;
        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    op_d  = op;
                    idx_d = '0;
                end
            end
            c_ST_RUN: begin
                c_out_d   = op_q ? w_diff : w_sum;
                c_valid_d = 1'b1;
                i_count_d = idx_q;
                if (idx_q != c_LAST) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            c_ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    assign c_out       = c_out_q;
    assign c_valid     = c_valid_q;
    assign done        = done_q;
    assign i_count_out = i_count_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_add_sub_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_add_sub_3x3
// Description : Self-checking bench for matrix_add_sub_3x3. Table of runs
//               (load data, op, expected stream) plus hand sequences for
//               out-of-range writes and reset mid-run. Expected elements are
//               queued when a run is started and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_add_sub_3x3;

    localparam int N  = 9;
    localparam int AW = 4;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 op;
    logic        [DW-1:0] a_in;
    logic        [AW-1:0] a_addr;
    logic                 a_wen;
    logic        [DW-1:0] b_in;
    logic        [AW-1:0] b_addr;
    logic                 b_wen;
    logic        [DW-1:0] c_out;
    logic                 c_valid;
    logic                 done;
    logic        [AW-1:0] i_count_out;

    matrix_add_sub_3x3 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a_in        (a_in),
        .a_addr      (a_addr),
        .a_wen       (a_wen),
        .b_in        (b_in),
        .b_addr      (b_addr),
        .b_wen       (b_wen),
        .c_out       (c_out),
        .c_valid     (c_valid),
        .done        (done),
        .i_count_out (i_count_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst === 1'b0 && c_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got idx %0d data %h required no output", i_count_out, c_out);
            end else begin
                mon_e = sb.pop_front();
                chk("stream_idx", 32'(i_count_out), 32'(mon_e.idx));
                chk("stream_data", c_out, mon_e.val);
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        string                 name;
        bit                    load;
        bit                    op;
        logic [N-1:0][DW-1:0]  a;
        logic [N-1:0][DW-1:0]  b;
        logic [N-1:0][DW-1:0]  exp;
    } vec_t;

    vec_t vecs[5];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic load(input logic [N-1:0][DW-1:0] a, input logic [N-1:0][DW-1:0] b);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            a_wen  = 1'b1;
            b_wen  = 1'b1;
            a_addr = AW'(i);
            b_addr = AW'(i);
            a_in   = a[i];
            b_in   = b[i];
        end
        @(negedge clk);
        a_wen = 1'b0;
        b_wen = 1'b0;
    endtask

    // Start at the next edge (edge k); c_valid expected after k+1..k+N,
    // done after k+N+1, done low again after k+N+2.
    task automatic run(input string name, input bit opv,
                       input logic [N-1:0][DW-1:0] exp, input bit poke);
        int done_cyc = -1;
        bit val_ok   = 1'b1;
        @(negedge clk);
        start = 1'b1;
        op    = opv;
        for (int i = 0; i < N; i++) sb.push_back('{idx: AW'(i), val: exp[i]});
        @(negedge clk);
        start = 1'b0;
        op    = ~opv;
        for (int c = 1; c <= 15 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c_valid !== (c <= N)) val_ok = 1'b0;
            if (done === 1'b1) done_cyc = c;
            start = (poke && c == 3);
        end
        start = 1'b0;
        chk({name, "_valid_window"}, 32'(val_ok), 32'd1);
        chk({name, "_done_cycle"}, 32'(done_cyc), 32'(N + 1));
        @(negedge clk);
        chk({name, "_done_low"}, 32'(done), 32'd0);
        chk({name, "_queue_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        bit seen;
        bit found;
        logic [N-1:0][DW-1:0] junk_a;

        // Table setup.
        vecs[0].name = "reset_contents"; vecs[0].load = 1'b0; vecs[0].op = 1'b0;
        vecs[1].name = "add_basic";      vecs[1].load = 1'b1; vecs[1].op = 1'b0;
        vecs[2].name = "sub_basic";      vecs[2].load = 1'b0; vecs[2].op = 1'b1;
        vecs[3].name = "add_wrap";       vecs[3].load = 1'b1; vecs[3].op = 1'b0;
        vecs[4].name = "sub_wrap";       vecs[4].load = 1'b0; vecs[4].op = 1'b1;
        for (int i = 0; i < N; i++) begin
            vecs[0].a[i] = '0;  vecs[0].b[i] = '0;  vecs[0].exp[i] = '0;
            vecs[1].a[i] = 32'(i + 1);
            vecs[1].b[i] = 32'd10;
            vecs[1].exp[i] = 32'(i + 11);
            vecs[2].a[i] = '0;  vecs[2].b[i] = '0;
            vecs[2].exp[i] = 32'(i - 9);
            vecs[3].a[i] = 32'(-100 * i);
            vecs[3].b[i] = 32'(7 * i + 3);
            vecs[3].exp[i] = 32'(-93 * i + 3);
            vecs[4].a[i] = '0;  vecs[4].b[i] = '0;
            vecs[4].exp[i] = 32'(-107 * i - 3);
        end
        vecs[3].a[0] = 32'h7FFF_FFFF; vecs[3].b[0] = 32'd1; vecs[3].exp[0] = 32'h8000_0000;
        vecs[3].a[1] = 32'h8000_0000; vecs[3].b[1] = 32'd1; vecs[3].exp[1] = 32'h8000_0001;
        vecs[4].exp[0] = 32'h7FFF_FFFE;
        vecs[4].exp[1] = 32'h7FFF_FFFF;

        // Reset state.
        rst = 1'b1; start = 1'b0; op = 1'b0;
        a_in = '0; a_addr = '0; a_wen = 1'b0;
        b_in = '0; b_addr = '0; b_wen = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_c_out",   c_out, 32'd0);
        chk("rst_c_valid", 32'(c_valid), 32'd0);
        chk("rst_done",    32'(done), 32'd0);
        chk("rst_i_count", 32'(i_count_out), 32'd0);
        rst = 1'b0;

        // Table-driven runs; run 1 also pokes start during RUN.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].load) load(vecs[v].a, vecs[v].b);
            run(vecs[v].name, vecs[v].op, vecs[v].exp, (v == 1));
        end

        // Out-of-range writes must leave the arrays untouched.
        for (int i = 0; i < N; i++) junk_a[i] = 32'hDEAD_0000 + 32'(i);
        for (int ad = 9; ad < 16; ad++) begin
            @(negedge clk);
            a_wen = 1'b1; b_wen = 1'b1;
            a_addr = AW'(ad); b_addr = AW'(ad);
            a_in = junk_a[ad - 9]; b_in = 32'hBEEF_0000;
        end
        @(negedge clk);
        a_wen = 1'b0; b_wen = 1'b0;
        run("oob_ignored", 1'b0, vecs[3].exp, 1'b0);

        // Reset while the run is at index 4.
        load(vecs[1].a, vecs[1].b);
        @(negedge clk);
        start = 1'b1; op = 1'b0;
        for (int i = 0; i < N; i++) sb.push_back('{idx: AW'(i), val: vecs[1].exp[i]});
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (c_valid === 1'b1 && i_count_out === 4'd4) found = 1'b1;
        end
        chk("abort_reached_idx4", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_c_out",   c_out, 32'd0);
        chk("abort_c_valid", 32'(c_valid), 32'd0);
        chk("abort_done",    32'(done), 32'd0);
        chk("abort_i_count", 32'(i_count_out), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (done !== 1'b0 || c_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Fresh load after reset.
        load(vecs[1].a, vecs[1].b);
        run("after_abort_add", 1'b0, vecs[1].exp, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
